// File: rtl/a1csa_seq_adder.sv
// Wide {cout,s} = a+b+cin, one 16-bit add-one carry-select slice per cycle, LSB first; SEQ_ADD_OVF_EN adds port ovf.
// Result valid WORDS+1 edges after accept; in_ready low while busy, result held in DONE until out_ready.

module a1csa16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [4:0] grp_c;

  assign grp_c[0] = cin;

  for (genvar g = 0; g < 4; g++) begin : g_grp
    logic [4:0] raw;
    logic [3:0] s_plus1;
    logic       c_plus1;

    assign raw = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]};
    // A carry-in of 1 is just an increment of the carry-in-0 group result.
    assign s_plus1 = raw[3:0] + 4'd1;
    assign c_plus1 = raw[4] | (&raw[3:0]);
    assign sum[4*g +: 4] = grp_c[g] ? s_plus1 : raw[3:0];
    assign grp_c[g+1]    = grp_c[g] ? c_plus1 : raw[4];
  end

  assign cout = grp_c[4];
endmodule

module a1csa_seq_adder #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  cin,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   s,
  output logic                  cout,
  output logic                  busy
`ifdef SEQ_ADD_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam int N  = 16 * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  s_q, s_d;
  logic          cout_q, cout_d;
`ifdef SEQ_ADD_OVF_EN
  logic          ovf_q, ovf_d;
`endif

  logic [15:0]   slice_a, slice_b;
  logic [15:0]   core_sum;
  logic          core_cout;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == CW'(w)) begin
        slice_a = a_q[16*w +: 16];
        slice_b = b_q[16*w +: 16];
      end
    end
  end

  a1csa16bits u_core (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cout_d    = cout_q;
`ifdef SEQ_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == CW'(w)) s_d[16*w +: 16] = core_sum;
        end
        carry_d = core_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = core_cout;
`ifdef SEQ_ADD_OVF_EN
          // Top sum bit is this slice's bit 15; s_q[N-1] is not written yet.
          ovf_d   = (a_q[N-1] == b_q[N-1]) && (core_sum[15] != a_q[N-1]);
`endif
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
`ifdef SEQ_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
`ifdef SEQ_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_a1csa_seq_adder.sv
// Directed and randomized checks of a1csa_seq_adder at WORDS = 1, 4 and 16 against a+b+cin arithmetic.
module tb_a1csa_seq_adder;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_v  [3];
  logic         out_ready_v [3];
  logic         cin_v       [3];
  logic [255:0] a_v         [3];
  logic [255:0] b_v         [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic         cout_v      [3];
  logic         busy_v      [3];
  logic [15:0]  s0;
  logic [63:0]  s1;
  logic [255:0] s2;
  logic [255:0] s_v [3];
`ifdef SEQ_ADD_OVF_EN
  logic         ovf0, ovf1, ovf2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign s_v[0] = {240'd0, s0};
  assign s_v[1] = {192'd0, s1};
  assign s_v[2] = s2;

  a1csa_seq_adder #(.WORDS(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .cin(cin_v[0]), .a(a_v[0][15:0]), .b(b_v[0][15:0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .s(s0), .cout(cout_v[0]), .busy(busy_v[0])
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf0)
`endif
  );

  a1csa_seq_adder #(.WORDS(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .cin(cin_v[1]), .a(a_v[1][63:0]), .b(b_v[1][63:0]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .s(s1), .cout(cout_v[1]), .busy(busy_v[1])
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  a1csa_seq_adder #(.WORDS(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .cin(cin_v[2]), .a(a_v[2]), .b(b_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .s(s2), .cout(cout_v[2]), .busy(busy_v[2])
`ifdef SEQ_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, {256'd0, obs}, {256'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int nw_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 16;
  endfunction

  function automatic logic [255:0] nmask(input int k);
    return (256'd1 << (16 * nw_of(k))) - 256'd1;
  endfunction

  // Reference: exact (N+1)-bit sum of the N-bit operands and carry-in.
  function automatic logic [256:0] model(input int k, input logic [255:0] a, input logic [255:0] b,
                                         input logic c);
    logic [256:0] m;
    logic [255:0] am;
    m  = (257'd1 << (16 * nw_of(k) + 1)) - 257'd1;
    am = nmask(k);
    return ({1'b0, a & am} + {1'b0, b & am} + {256'd0, c}) & m;
  endfunction

  function automatic logic [256:0] observed(input int k);
    return ({256'd0, cout_v[k]} << (16 * nw_of(k))) | {1'b0, s_v[k]};
  endfunction

  function automatic logic [255:0] r256();
    logic [255:0] r;
    int sel;
    sel = $urandom_range(7);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    if (sel == 0) r = '1;
    else if (sel == 1) r = '0;
    return r;
  endfunction

  task automatic accept(input int k, input logic [255:0] a, input logic [255:0] b, input logic c);
    a_v[k] = a;
    b_v[k] = b;
    cin_v[k] = c;
    in_valid_v[k] = 1'b1;
    chkb("accept_in_ready", in_ready_v[k], 1'b1);
    tick();
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!out_valid_v[k] && n < 200) begin
      tick();
      n++;
    end
    chkb("wait_out_valid", out_valid_v[k], 1'b1);
  endtask

  task automatic release_result(input int k);
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    chkb("release_out_valid", out_valid_v[k], 1'b0);
    chkb("release_in_ready", in_ready_v[k], 1'b1);
  endtask

  initial begin
    logic [256:0] exp;
    logic [256:0] q[$];
    logic         seen;
    logic         take_in, take_out;
    int           acc, dlv, cyc, nops;

    for (int k = 0; k < 3; k++) begin
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b0;
      cin_v[k] = 1'b0;
      a_v[k] = '0;
      b_v[k] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;

    chkb("rst_out_valid", out_valid_v[1], 1'b0);
    chkb("rst_in_ready", in_ready_v[1], 1'b1);
    chkb("rst_busy", busy_v[1], 1'b0);
    chk("rst_sum", observed(1), 257'd0);
    chkb("rst_w16_in_ready", in_ready_v[2], 1'b1);

    // Carry across slice 0 -> 1, out_ready held high throughout.
    out_ready_v[1] = 1'b1;
    accept(1, 256'hFFFF, 256'h1, 1'b0);
    chkb("t1_busy", busy_v[1], 1'b1);
    chkb("t1_in_ready_low", in_ready_v[1], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("t1_run_no_valid", out_valid_v[1], 1'b0);
    end
    tick();
    chkb("t1_out_valid", out_valid_v[1], 1'b1);
    chk("t1_sum", observed(1), 257'h1_0000);
    tick();
    chkb("t1_done_one_cycle", out_valid_v[1], 1'b0);
    chkb("t1_in_ready_back", in_ready_v[1], 1'b1);
    out_ready_v[1] = 1'b0;

    // Full carry ripple; operands are scrambled during RUN.
    accept(1, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd0, 1'b1);
    a_v[1] = r256();
    b_v[1] = r256();
    cin_v[1] = 1'b0;
    wait_valid(1);
    chk("t2_ones_cin1", observed(1), {192'd0, 1'b1, 64'd0});
    release_result(1);
    accept(1, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 256'd0, 1'b0);
    wait_valid(1);
    chk("t2_ones_cin0", observed(1), {193'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    release_result(1);

    // Backpressure: result held while requester pokes the busy block.
    accept(1, 256'h1234_5678_9ABC_DEF0, 256'hFEDC_BA98_7654_3210, 1'b1);
    exp = 257'h1_1111_1111_1111_1101;
    wait_valid(1);
    for (int i = 0; i < 5; i++) begin
      in_valid_v[1] = i[0];
      a_v[1] = r256();
      tick();
      chk("t3_hold_sum", observed(1), exp);
      chkb("t3_in_ready", in_ready_v[1], 1'b0);
      chkb("t3_busy", busy_v[1], 1'b1);
    end
    in_valid_v[1] = 1'b0;
    release_result(1);

    // Reset two cycles into RUN discards the operation.
    accept(1, 256'hAAAA_5555, 256'h5555_AAAA, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkb("t4_out_valid", out_valid_v[1], 1'b0);
    chkb("t4_in_ready", in_ready_v[1], 1'b1);
    chkb("t4_busy", busy_v[1], 1'b0);
    chk("t4_sum_cleared", observed(1), 257'd0);
    seen = 1'b0;
    out_ready_v[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      seen = seen | out_valid_v[1];
      tick();
    end
    out_ready_v[1] = 1'b0;
    chkb("t4_no_stray_valid", seen, 1'b0);

`ifdef SEQ_ADD_OVF_EN
    accept(1, 256'h7FFF_FFFF_FFFF_FFFF, 256'd1, 1'b0);
    wait_valid(1);
    chk("t6_pos_ovf_sum", observed(1), 257'h8000_0000_0000_0000);
    chkb("t6_pos_ovf", ovf1, 1'b1);
    release_result(1);
    accept(1, 256'h8000_0000_0000_0000, 256'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_valid(1);
    chk("t6_neg_ovf_sum", observed(1), 257'h1_7FFF_FFFF_FFFF_FFFF);
    chkb("t6_neg_ovf", ovf1, 1'b1);
    release_result(1);
    accept(1, 256'd5, 256'd3, 1'b0);
    wait_valid(1);
    chk("t6_small_sum", observed(1), 257'd8);
    chkb("t6_no_ovf", ovf1, 1'b0);
    release_result(1);
`endif

    // Randomized back-to-back traffic with consumer stalls, scoreboarded.
    for (int k = 0; k < 3; k++) begin
      nops = (k == 2) ? 200 : 400;
      acc = 0;
      dlv = 0;
      cyc = 0;
      q.delete();
      while ((acc < nops || q.size() > 0 || in_valid_v[k]) && cyc < 30000) begin
        if (!in_valid_v[k]) begin
          a_v[k] = r256();
          b_v[k] = r256();
          cin_v[k] = 1'($urandom);
          if (acc < nops && $urandom_range(3) != 0) in_valid_v[k] = 1'b1;
        end
        out_ready_v[k] = ($urandom_range(3) != 0);
        take_in  = in_valid_v[k] && in_ready_v[k];
        take_out = out_valid_v[k] && out_ready_v[k];
        if (take_out) begin
          if (q.size() == 0) chkb("rnd_unexpected_result", 1'b1, 1'b0);
          else chk("rnd_sum", observed(k), q.pop_front());
          dlv++;
        end
        if (take_in) begin
          q.push_back(model(k, a_v[k], b_v[k], cin_v[k]));
          acc++;
        end
        tick();
        if (take_in) in_valid_v[k] = 1'b0;
        cyc++;
      end
      out_ready_v[k] = 1'b0;
      in_valid_v[k] = 1'b0;
      chk("rnd_accepted", 257'(acc), 257'(nops));
      chk("rnd_delivered", 257'(dlv), 257'(acc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/a1csa_seq_adder.md
Name: a1csa_seq_adder

Overview:
Multi-cycle wide adder sequencer. It time-multiplexes one instance of the team's 16-bit add-one carry-select adder core (a1csa16bits) to add two WORDS*16-bit operands. Each cycle it processes one 16-bit slice, LSB slice first, and chains the slice carry-out through a carry register. It sits between a requester and a consumer, with valid/ready handshakes on both sides.

Parameters:
WORDS  4  number of 16-bit slices; operand width N = 16*WORDS; legal range 1..16
CW  derived ($clog2(WORDS) min 1)  slice index counter width (localparam, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
cin  input  1  carry into slice 0
a  input  N  operand A
b  input  N  operand B
out_valid  output  1  result available
out_ready  input  1  consumer takes result
s  output  N  sum (registered)
cout  output  1  carry out of the top slice (registered)
busy  output  1  high in RUN and DONE

Behaviour:
- Datapath and clocking:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high; it overrides every other input in the same cycle.
- Reset values:
  - state=IDLE, slice index=0, carry register=0, operand registers=0, s=0, cout=0.
  - out_valid=0, in_ready=1, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, b; carry register<=cin; index<=0; s<=0; go to RUN.
  - in_valid low: stay in IDLE; no register changes.
- RUN:
  - in_ready=0.
  - Adder core inputs:
    - slice operands = a_reg[16*idx +: 16] and b_reg[16*idx +: 16]
    - core cin = carry register.
  - Each cycle: s[16*idx +: 16] <= core sum; carry register <= core cout; idx <= idx+1.
  - When idx==WORDS-1: cout <= core cout; go to DONE; idx not incremented further.
- DONE:
  - out_valid=1; s and cout are held stable; in_ready=0.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - No same-cycle new accept; in_ready rises in the cycle after the handshake.
- Latency and throughput:
  - Accept at edge E0; slices written at edges E1..EWORDS; out_valid high starting in the cycle after EWORDS.
  - Best-case throughput: one operation per WORDS+2 cycles.
- Arithmetic:
  - {cout, s} = a + b + cin, modulo 2^(N+1), exact.
  - During RUN, s holds partial results; s is meaningful only while out_valid=1.
- Boundary conditions:
  - WORDS=1: RUN lasts exactly one cycle.
  - in_valid while not IDLE: ignored; operands are not sampled; requester must hold.
  - out_ready high outside DONE: no effect.
  - out_ready held high continuously: DONE lasts exactly one cycle.
  - Carry chain across all slices, e.g. all-ones + 0 + cin=1: each RUN cycle propagates correctly through the carry register.
  - rst in RUN or DONE: next cycle state=IDLE, out_valid=0, in_ready=1, s=0, cout=0; the in-flight operation is discarded with no partial output.
  - Input operands are sampled only at accept; later changes to a/b/cin do not affect the in-flight result.

Optional Feature:
SEQ_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow of the full N-bit add.
  - ovf = (a_reg[N-1]==b_reg[N-1]) && (s[N-1]!=a_reg[N-1]).
  - Registered in the same edge as cout; valid with out_valid; reset to 0.
- Undefined:
  - Port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
1. WORDS=4, a=0x0000_0000_0000_FFFF, b=0x1, cin=0, in_valid pulse -> out_valid rises in the cycle after accept+4 edges; s=0x0000_0000_0001_0000, cout=0.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0x0, cout=1. Same operands with cin=0 -> s=all-ones, cout=0.
3. Backpressure: complete an op, hold out_ready=0 for 5 cycles while toggling in_valid and a -> s/cout stable, in_ready=0, busy=1. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
4. Reset mid-operation: assert rst for one cycle two cycles after accept -> next cycle state IDLE, out_valid=0, s=0, cout=0. No out_valid appears until a new accept.
5. 1000 random back-to-back operations, random out_ready stalls, and WORDS in {1,4,16} -> every {cout,s} equals the model a+b+cin; operation count accepted == count delivered.
6. With SEQ_ADD_OVF_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> ovf=1, s=0x8000_0000_0000_0000. Then a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> ovf=1, cout=1. Then a=5, b=3 -> ovf=0.
